// File: rtl/vme_cmd_responder.sv
// Slave end of the VME command channel: accepts one command and runs
// a single access on the 16-bit register bus, then returns status/data.
module vme_cmd_responder #(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [7:0]  ADDR_TAG       = 8'hA8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] vme_cmd_reg,
    input  logic [31:0] vme_dat_reg_in,
    output logic        vme_cmd_rd,
    output logic        vme_dat_wr,
    output logic [31:0] vme_dat_reg_out,
    output logic [15:0] bus_addr,
    output logic [15:0] bus_wdata,
    output logic        bus_rd,
    output logic        bus_wr,
    input  logic        bus_ack,
    input  logic [15:0] bus_rdata,
    output logic        busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DECODE = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state;
    logic [25:0] cmd_q;
    logic [15:0] wdat_q;
    logic [15:0] cnt;
    logic        bad_cmd;
    logic        unused_bits;

    assign unused_bits = ^{vme_cmd_reg[31:26], vme_dat_reg_in[31:16]};

    always_comb begin
        bad_cmd = (cmd_q[23:16] != ADDR_TAG)
                | (cmd_q[25] & cmd_q[24])
                | (!cmd_q[25] & !cmd_q[24]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            cmd_q           <= '0;
            wdat_q          <= '0;
            cnt             <= '0;
            vme_cmd_rd      <= 1'b0;
            vme_dat_wr      <= 1'b0;
            vme_dat_reg_out <= '0;
            bus_addr        <= '0;
            bus_wdata       <= '0;
            bus_rd          <= 1'b0;
            bus_wr          <= 1'b0;
            busy            <= 1'b0;
        end else begin
            vme_dat_wr <= 1'b0;
            case (state)
                S_IDLE: begin
                    // start only counts once ready has been advertised
                    if (vme_cmd_rd && start) begin
                        cmd_q      <= vme_cmd_reg[25:0];
                        wdat_q     <= vme_dat_reg_in[15:0];
                        vme_cmd_rd <= 1'b0;
                        busy       <= 1'b1;
                        state      <= S_DECODE;
                    end else begin
                        vme_cmd_rd <= 1'b1;
                    end
                end
                S_DECODE: begin
                    if (bad_cmd) begin
                        vme_dat_reg_out <= 32'h0002_0000;
                        vme_dat_wr      <= 1'b1;
                        state           <= S_RESP;
                    end else begin
                        bus_addr  <= cmd_q[15:0];
                        bus_wdata <= wdat_q;
                        bus_rd    <= cmd_q[25];
                        bus_wr    <= cmd_q[24];
                        cnt       <= '0;
                        state     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // ack wins over a timeout landing on the same cycle
                    if (bus_ack) begin
                        bus_rd          <= 1'b0;
                        bus_wr          <= 1'b0;
                        vme_dat_reg_out <= {16'h0000,
                                            cmd_q[25] ? bus_rdata : wdat_q};
                        vme_dat_wr      <= 1'b1;
                        state           <= S_RESP;
                    end else if (cnt == CNT_LAST) begin
                        bus_rd          <= 1'b0;
                        bus_wr          <= 1'b0;
                        vme_dat_reg_out <= 32'h0001_0000;
                        vme_dat_wr      <= 1'b1;
                        state           <= S_RESP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_RESP: begin
                    vme_cmd_rd <= 1'b1;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vme_cmd_responder.sv
// Directed bench for vme_cmd_responder: vector table plus protocol,
// back-to-back and reset sequences.
module tb_vme_cmd_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] vme_cmd_reg = '0;
    logic [31:0] vme_dat_reg_in = '0;
    logic        vme_cmd_rd;
    logic        vme_dat_wr;
    logic [31:0] vme_dat_reg_out;
    logic [15:0] bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_rd;
    logic        bus_wr;
    logic        bus_ack = 1'b0;
    logic [15:0] bus_rdata = '0;
    logic        busy;

    vme_cmd_responder #(.TIMEOUT_CYCLES(16), .ADDR_TAG(8'hA8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .vme_cmd_reg(vme_cmd_reg), .vme_dat_reg_in(vme_dat_reg_in),
        .vme_cmd_rd(vme_cmd_rd), .vme_dat_wr(vme_dat_wr),
        .vme_dat_reg_out(vme_dat_reg_out),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rd(bus_rd), .bus_wr(bus_wr),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] cmd;
        logic [31:0] dat;
        int          ack_at;
        logic [15:0] rdata;
        logic [31:0] resp;
        int          rd_n;
        int          wr_n;
        int          lat;
        logic [15:0] addr;
        logic [15:0] wd;
    } vec_t;

    vec_t vecs[8];

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!vme_cmd_rd && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready"}, {31'b0, vme_cmd_rd}, 32'h1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int rdc, wrc, strn, pulses, lat, rdy;
        logic [31:0] resp;
        logic [15:0] a, w;
        rdc = 0; wrc = 0; strn = 0; pulses = 0; lat = 0; rdy = 0;
        resp = '0; a = '0; w = '0;
        wait_ready(tag);
        vme_cmd_reg    = v.cmd;
        vme_dat_reg_in = v.dat;
        bus_rdata      = v.rdata;
        start          = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int e = 2; e < 60 && rdy == 0; e++) begin
            @(negedge clk);
            bus_ack = 1'b0;
            if (bus_rd) rdc++;
            if (bus_wr) wrc++;
            if (bus_rd || bus_wr) begin
                a = bus_addr;
                w = bus_wdata;
                strn++;
                if (strn == v.ack_at) bus_ack = 1'b1;
            end
            if (vme_dat_wr) begin
                pulses++;
                if (lat == 0) lat = e;
                resp = vme_dat_reg_out;
            end
            if (vme_cmd_rd && pulses > 0) rdy = e;
        end
        bus_ack = 1'b0;
        chk({tag, "_resp"}, resp, v.resp);
        chk({tag, "_rd_cycles"}, rdc, v.rd_n);
        chk({tag, "_wr_cycles"}, wrc, v.wr_n);
        chk({tag, "_latency"}, lat, v.lat);
        chk({tag, "_cmd_rd_edge"}, rdy, v.lat + 1);
        chk({tag, "_pulses"}, pulses, 1);
        chk({tag, "_hold"}, vme_dat_reg_out, v.resp);
        if (v.rd_n + v.wr_n > 0) begin
            chk({tag, "_addr"}, {16'h0, a}, {16'h0, v.addr});
            chk({tag, "_wdata"}, {16'h0, w}, {16'h0, v.wd});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses, rdc, wrc, act;

        vecs[0] = '{32'h01A8_4004, 32'h0000_1234, 3, 16'h0000,
                    32'h0000_1234, 0, 3, 5, 16'h4004, 16'h1234};
        vecs[1] = '{32'h02A8_300C, 32'h0000_0000, 1, 16'hBEEF,
                    32'h0000_BEEF, 1, 0, 3, 16'h300C, 16'h0000};
        vecs[2] = '{32'h02A8_0010, 32'h0000_0000, 0, 16'hDEAD,
                    32'h0001_0000, 16, 0, 18, 16'h0010, 16'h0000};
        vecs[3] = '{32'h02A8_0010, 32'h0000_0000, 16, 16'h5A5A,
                    32'h0000_5A5A, 16, 0, 18, 16'h0010, 16'h0000};
        vecs[4] = '{32'h02B0_0000, 32'h0000_0000, 1, 16'h0000,
                    32'h0002_0000, 0, 0, 2, 16'h0000, 16'h0000};
        vecs[5] = '{32'h03A8_0000, 32'h0000_0000, 1, 16'h0000,
                    32'h0002_0000, 0, 0, 2, 16'h0000, 16'h0000};
        vecs[6] = '{32'h00A8_0000, 32'h0000_0000, 1, 16'h0000,
                    32'h0002_0000, 0, 0, 2, 16'h0000, 16'h0000};
        vecs[7] = '{32'h01A8_FFFF, 32'hFFFF_8001, 1, 16'h0000,
                    32'h0000_8001, 0, 1, 3, 16'hFFFF, 16'h8001};

        // reset state
        #12;
        chk("rst_outs", {vme_cmd_rd, vme_dat_wr, bus_rd, bus_wr, busy},
            32'h0);
        chk("rst_dat_out", vme_dat_reg_out, 32'h0);
        chk("rst_bus", {bus_addr, bus_wdata}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_cmd_rd_low", {31'b0, vme_cmd_rd}, 32'h0);
        @(negedge clk);
        chk("rel_cmd_rd_high", {31'b0, vme_cmd_rd}, 32'h1);

        for (int i = 0; i < 8; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // ack pulses while idle must do nothing
        wait_ready("idle_ack");
        act = 0;
        bus_ack = 1'b1;
        for (int e = 0; e < 5; e++) begin
            @(negedge clk);
            if (busy || bus_rd || bus_wr || vme_dat_wr) act++;
        end
        bus_ack = 1'b0;
        chk("idle_ack_activity", act, 0);

        // start pulses while busy are ignored
        wait_ready("busy_start");
        vme_cmd_reg = 32'h01A8_0100;
        vme_dat_reg_in = 32'h0000_7777;
        start = 1'b1;
        @(negedge clk);
        vme_cmd_reg = 32'h02A8_0200;
        pulses = 0; rdc = 0; wrc = 0;
        for (int e = 2; e <= 14; e++) begin
            @(negedge clk);
            start = busy;
            bus_ack = (e == 5);
            if (bus_rd) rdc++;
            if (bus_wr) wrc++;
            if (vme_dat_wr) begin
                pulses++;
                chk("busy_start_resp", vme_dat_reg_out, 32'h0000_7777);
            end
        end
        start = 1'b0;
        bus_ack = 1'b0;
        chk("busy_start_pulses", pulses, 1);
        chk("busy_start_wr", wrc, 4);
        chk("busy_start_rd", rdc, 0);

        // start held high: one response every four edges
        wait_ready("held");
        vme_cmd_reg = 32'h02A8_0020;
        bus_rdata = 16'h1111;
        bus_ack = 1'b1;
        start = 1'b1;
        @(negedge clk);
        pulses = 0; rdc = 0;
        for (int e = 2; e <= 20; e++) begin
            @(negedge clk);
            if (bus_rd) rdc++;
            if (vme_dat_wr) begin
                pulses++;
                chk("held_resp", vme_dat_reg_out, 32'h0000_1111);
            end
        end
        start = 1'b0;
        bus_ack = 1'b0;
        chk("held_pulses", pulses, 5);
        chk("held_strobes", rdc, 5);

        // reset in the middle of an access
        wait_ready("mid_rst");
        vme_cmd_reg = 32'h02A8_0040;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_strobe_before", {31'b0, bus_rd}, 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_strobes", {30'b0, bus_rd, bus_wr}, 32'h0);
        chk("mid_rst_flags", {29'b0, vme_dat_wr, vme_cmd_rd, busy}, 32'h0);
        chk("mid_rst_dat_out", vme_dat_reg_out, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rel_cmd_rd_low", {31'b0, vme_cmd_rd}, 32'h0);
        @(negedge clk);
        chk("mid_rel_cmd_rd_high", {31'b0, vme_cmd_rd}, 32'h1);
        run_vec(vecs[1], "post_rst");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/vme_cmd_responder.md
Name: vme_cmd_responder

Overview:
Synthesizable slave end of the simulation VME command channel. The bench file driver issues start with a 32-bit command word and a data word, then waits for vme_dat_wr. This block accepts that command and runs one access on the internal 16-bit register bus. It then returns read data (or echoed write data) plus status on vme_dat_reg_out, and advertises readiness for the next command on vme_cmd_rd.

Parameters:
TIMEOUT_CYCLES, 255, number of ACCESS cycles the bus strobe is held without bus_ack before timeout; legal range 1..65535.
ADDR_TAG, 8'hA8, required value of command bits [23:16].

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  command valid; sampled only when vme_cmd_rd=1.
vme_cmd_reg  in  32  command: [25]=read, [24]=write, [23:16]=tag, [15:0]=register address.
vme_dat_reg_in  in  32  write data; [15:0] used.
vme_cmd_rd  out  1  ready to accept a command.
vme_dat_wr  out  1  one-cycle pulse; vme_dat_reg_out valid.
vme_dat_reg_out  out  32  response: [15:0]=data, [16]=timeout, [17]=bad_cmd, [31:18]=0.
bus_addr  out  16  register address.
bus_wdata  out  16  register write data.
bus_rd  out  1  read strobe, level, held until ack/timeout.
bus_wr  out  1  write strobe, level, held until ack/timeout.
bus_ack  in  1  slave completion; qualified only in ACCESS.
bus_rdata  in  16  read data, sampled on the ack cycle.
busy  out  1  high in every state except IDLE.

Behaviour:
- All outputs are registered.
- Reset values: vme_cmd_rd=0, vme_dat_wr=0, vme_dat_reg_out=0, bus_addr=0, bus_wdata=0, bus_rd=0, bus_wr=0, busy=0. The state machine goes to IDLE.
- The first posedge after rst deasserts sets vme_cmd_rd=1.
- Asserting rst mid-operation drops all strobes immediately, with no response pulse.
- States: IDLE, DECODE, ACCESS, RESP.
- IDLE:
  - vme_cmd_rd=1.
  - At a posedge with start=1, latch vme_cmd_reg and vme_dat_reg_in[15:0], clear vme_cmd_rd, go to DECODE.
  - start=0 is ignored and the block stays in IDLE.
- DECODE (1 cycle):
  - bad_cmd = (tag!=ADDR_TAG) | (bit25 & bit24) | (!bit25 & !bit24).
  - If bad_cmd: go to RESP with response {14'b0, 1'b1, 1'b0, 16'h0000}; no bus strobe ever asserts.
  - Otherwise: drive bus_addr and bus_wdata, assert bus_rd (bit25) or bus_wr (bit24), clear the 16-bit timeout counter, go to ACCESS.
- ACCESS:
  - Strobe and address stay stable.
  - bus_ack=1: drop the strobe. For a read, the response data is bus_rdata; for a write, it is the latched write data. Timeout bit = 0. Go to RESP.
  - bus_ack=0 with counter==TIMEOUT_CYCLES-1: drop the strobe, response {..timeout=1.., data=16'h0000}, go to RESP.
  - Otherwise the counter increments.
  - The strobe is therefore high for exactly TIMEOUT_CYCLES cycles on a timeout.
- RESP (1 cycle):
  - vme_dat_wr=1 and vme_dat_reg_out is loaded in the same edge.
  - Next edge: vme_dat_wr=0, vme_cmd_rd=1, go to IDLE.
  - vme_dat_reg_out holds its value until the next response or reset.
- Latency, counting from the edge that samples start:
  - valid command, ack on first ACCESS cycle: vme_dat_wr high after edge 3;
  - bad command: vme_dat_wr high after edge 2;
  - vme_cmd_rd high again after edge 4 (valid, immediate ack).
- start while vme_cmd_rd=0 is ignored; no queueing.
- bus_ack outside ACCESS is ignored.
- An ack on the same cycle the counter hits its limit counts as an ack, not a timeout.
- Back-to-back: start held high is accepted again on the first IDLE edge.

Test Plan:
- Write: cmd 0x01A8_4004, data 0x0000_1234, ack on 3rd ACCESS cycle -> bus_addr=0x4004, bus_wdata=0x1234, bus_wr high 3 cycles, single vme_dat_wr pulse with vme_dat_reg_out=0x0000_1234, bus_rd never high.
- Read: cmd 0x02A8_300C, bus_rdata=0xBEEF, immediate ack -> bus_rd high 1 cycle, vme_dat_wr after edge 3, vme_dat_reg_out=0x0000_BEEF, vme_cmd_rd high after edge 4.
- Timeout (TIMEOUT_CYCLES=16): read 0x02A8_0010, no ack -> bus_rd high exactly 16 cycles, vme_dat_reg_out=0x0001_0000. Repeat with ack on 16th cycle -> timeout bit 0.
- Bad commands: 0x02B0_0000 (tag), 0x03A8_0000 (both bits), 0x00A8_0000 (neither) -> no strobe, vme_dat_wr after edge 2, vme_dat_reg_out=0x0002_0000.
- Protocol: start pulses during DECODE/ACCESS/RESP and bus_ack pulses in IDLE -> no extra access or response. start held high -> consecutive commands each produce exactly one response.
- Reset: assert rst mid-ACCESS -> bus_rd/bus_wr low asynchronously, no vme_dat_wr, vme_dat_reg_out=0. vme_cmd_rd=0 until the first posedge after release, then a new read completes normally.
